// File: rtl/truth_table_checker_if.sv
// Bus bundle between the truth-table checker and its driver / gate under test.
interface truth_table_checker_if;
    logic       start;
    logic       dut_y;
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_mask;
    logic [2:0] err_count;

    // Requester side: issues start, returns the gate response, observes results.
    modport master (
        output start, dut_y,
        input  a, b, busy, done, pass, fail_mask, err_count
    );

    // Checker side.
    modport slave (
        input  start, dut_y,
        output a, b, busy, done, pass, fail_mask, err_count
    );
endinterface

// File: rtl/truth_table_checker.sv
// Exhaustive 2-input gate checker: walks vectors {b,a} = 0..3, holds each for
// HOLD_CYCLES clocks, samples dut_y on the last hold edge and compares it with
// the EXPECTED truth table. Results stay visible until the next start or reset.
module truth_table_checker #(
    parameter int unsigned HOLD_CYCLES = 2,
    parameter logic [3:0]  EXPECTED    = 4'b0111
) (
    input logic                  clk,
    input logic                  rst,
    truth_table_checker_if.slave bus
);

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [3:0] hcnt_q, hcnt_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [3:0] fail_mask_q, fail_mask_d;
    logic [2:0] err_count_q, err_count_d;
    logic       mismatch;

    // Next-state and next-output logic for the sweep sequencer.
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        hcnt_d      = hcnt_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_mask_d = fail_mask_q;
        err_count_d = err_count_q;
        mismatch    = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d     = DRIVE;
                    vec_d       = 2'd0;
                    hcnt_d      = 4'd0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    fail_mask_d = 4'd0;
                    err_count_d = 3'd0;
                end
            end
            DRIVE: begin
                if (hcnt_q < HOLD_LAST) begin
                    hcnt_d = hcnt_q + 4'd1;
                end else begin
                    // Case inequality so an X/Z response is treated as a mismatch.
                    mismatch = (bus.dut_y !== EXPECTED[vec_q]);
                    if (mismatch) begin
                        fail_mask_d[vec_q] = 1'b1;
                        err_count_d        = err_count_q + 3'd1;
                    end
                    if (vec_q != 2'd3) begin
                        vec_d  = vec_q + 2'd1;
                        hcnt_d = 4'd0;
                    end else begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_count_d == 3'd0);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Stimulus always mirrors the (next) vector index, so it holds in DONE.
        a_d = vec_d[0];
        b_d = vec_d[1];
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            vec_q       <= 2'd0;
            hcnt_q      <= 4'd0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_mask_q <= 4'd0;
            err_count_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            hcnt_q      <= hcnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_mask_q <= fail_mask_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.fail_mask = fail_mask_q;
    assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: a default instance (HOLD=2, NAND) and a
// HOLD=1 / AND instance, each fed by a gate model given as a 4-bit table.
module tb_truth_table_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    int         checks = 0;
    int         passed = 0;
    logic [3:0] resp0, resp1;
    logic       glitch0;
    logic       sel;

    truth_table_checker_if t0 ();
    truth_table_checker_if t1 ();

    // Gate models: response looked up from a table indexed by {b,a};
    // glitch0 corrupts instance 0's response on non-sample cycles.
    assign t0.dut_y = glitch0 ? ~resp0[{t0.b, t0.a}] : resp0[{t0.b, t0.a}];
    assign t1.dut_y = resp1[{t1.b, t1.a}];

    truth_table_checker dut0 (
        .clk (clk),
        .rst (rst),
        .bus (t0.slave)
    );

    truth_table_checker #(
        .HOLD_CYCLES (1),
        .EXPECTED    (4'b1000)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (t1.slave)
    );

    wire       cur_busy = sel ? t1.busy : t0.busy;
    wire       cur_done = sel ? t1.done : t0.done;
    wire       cur_pass = sel ? t1.pass : t0.pass;
    wire       cur_a    = sel ? t1.a    : t0.a;
    wire       cur_b    = sel ? t1.b    : t0.b;
    wire [3:0] cur_fm   = sel ? t1.fail_mask : t0.fail_mask;
    wire [2:0] cur_ec   = sel ? t1.err_count : t0.err_count;

    task automatic set_start(input logic v);
        if (sel) t1.start = v;
        else     t0.start = v;
    endtask

    // One full sweep on the selected instance, checked against a table-level model.
    task automatic run_sweep(input string name, input bit use1, input logic [3:0] tt,
                             input bit glitch_en, input bit poke);
        int         h, c, guard, seq_err, exp_err;
        logic [3:0] exp_tt, exp_mask;
        logic [1:0] v;
        sel      = use1;
        h        = use1 ? 1 : 2;
        exp_tt   = use1 ? 4'b1000 : 4'b0111;
        if (use1) resp1 = tt;
        else      resp0 = tt;
        exp_mask = exp_tt ^ tt;
        exp_err  = $countones(exp_mask);
        @(negedge clk);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        c = 0; guard = 0; seq_err = 0;
        while (cur_busy === 1'b1 && guard < 64) begin
            v = 2'(c / h);
            if ({cur_b, cur_a} !== v) seq_err++;
            glitch0 = glitch_en && !use1 && ((c % h) != h - 1);
            if (poke && c == 3) set_start(1'b1);
            else                set_start(1'b0);
            c++; guard++;
            @(negedge clk);
        end
        glitch0 = 1'b0;
        set_start(1'b0);
        checks++;
        if (guard >= 64) $display("FAIL %s timeout: busy still %b after %0d cycles, required drop by %0d", name, cur_busy, guard, 4*h);
        else passed++;
        checks++;
        if (c !== 4*h) $display("FAIL %s busy_cycles: got %0d required %0d", name, c, 4*h);
        else passed++;
        checks++;
        if (seq_err !== 0) $display("FAIL %s ab_sequence: %0d wrong cycles, required 0", name, seq_err);
        else passed++;
        checks++;
        if ({cur_done, cur_pass} !== {1'b1, exp_err == 0})
            $display("FAIL %s done_pass: got %b%b required 1%b", name, cur_done, cur_pass, exp_err == 0);
        else passed++;
        checks++;
        if (cur_fm !== exp_mask) $display("FAIL %s fail_mask: got %b required %b", name, cur_fm, exp_mask);
        else passed++;
        checks++;
        if (cur_ec !== 3'(exp_err)) $display("FAIL %s err_count: got %0d required %0d", name, cur_ec, exp_err);
        else passed++;
        @(negedge clk);
        checks++;
        if ({cur_done, cur_busy, cur_b, cur_a, cur_fm, cur_ec} !== {1'b1, 1'b0, 2'b11, exp_mask, 3'(exp_err)})
            $display("FAIL %s done_hold: got d%b busy%b ab%b%b fm%b ec%0d required d1 busy0 ab11 fm%b ec%0d",
                     name, cur_done, cur_busy, cur_b, cur_a, cur_fm, cur_ec, exp_mask, exp_err);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            checks++;
            if ({cur_busy, cur_done, cur_pass, cur_fm, cur_ec, cur_a, cur_b} !== 11'd0)
                $display("FAIL reset_state inst%0d: got %b required all zero", s,
                         {cur_busy, cur_done, cur_pass, cur_fm, cur_ec, cur_a, cur_b});
            else passed++;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        run_sweep("nand", 1'b0, 4'b0111, 1'b0, 1'b0);
        run_sweep("tied1", 1'b0, 4'b1111, 1'b0, 1'b0);
        run_sweep("and", 1'b0, 4'b1000, 1'b0, 1'b0);
        run_sweep("glitch_ignored", 1'b0, 4'b0111, 1'b1, 1'b0);
        run_sweep("start_in_drive", 1'b0, 4'b0110, 1'b0, 1'b1);
        run_sweep("hold1_and", 1'b1, 4'b1000, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            run_sweep($sformatf("rand%0d", i), i[0], 4'($urandom), 1'b1, (i % 3) == 0);
        end
    endtask

    task automatic test_reset_mid_sweep();
        sel   = 1'b0;
        resp0 = 4'b1000;
        @(negedge clk);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        repeat (4) @(negedge clk);
        checks++;
        if ({cur_busy, cur_b, cur_a} !== 3'b110)
            $display("FAIL midreset_at_vec2: got busy%b ab%b%b required busy1 b1 a0", cur_busy, cur_b, cur_a);
        else passed++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({cur_busy, cur_done, cur_pass, cur_fm, cur_ec, cur_a, cur_b} !== 11'd0)
            $display("FAIL midreset_cleared: got %b required all zero",
                     {cur_busy, cur_done, cur_pass, cur_fm, cur_ec, cur_a, cur_b});
        else passed++;
        @(negedge clk);
        checks++;
        if ({cur_busy, cur_done} !== 2'b00)
            $display("FAIL midreset_stays_idle: got busy%b done%b required 00", cur_busy, cur_done);
        else passed++;
        run_sweep("after_reset", 1'b0, 4'b0111, 1'b0, 1'b0);
    endtask

    task automatic test_start_held();
        int guard;
        sel   = 1'b0;
        resp0 = 4'b1111;
        @(negedge clk);
        set_start(1'b1);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            checks++;
            if ({cur_busy, cur_done} !== {(n % 9) != 0, (n % 9) == 0})
                $display("FAIL held_start_n%0d: got busy%b done%b required busy%b done%b",
                         n, cur_busy, cur_done, (n % 9) != 0, (n % 9) == 0);
            else passed++;
            if (n == 9) begin
                checks++;
                if (cur_ec !== 3'd1) $display("FAIL held_first_result: got err %0d required 1", cur_ec);
                else passed++;
            end
            if (n == 10) begin
                checks++;
                if ({cur_fm, cur_ec} !== 7'd0)
                    $display("FAIL held_restart_clear: got fm%b ec%0d required 0000 0", cur_fm, cur_ec);
                else passed++;
            end
        end
        set_start(1'b0);
        guard = 0;
        while (cur_done !== 1'b1 && guard < 32) begin
            guard++;
            @(negedge clk);
        end
        checks++;
        if ({cur_done, cur_pass, cur_fm, cur_ec} !== {1'b1, 1'b0, 4'b1000, 3'd1})
            $display("FAIL held_final: got d%b p%b fm%b ec%0d required d1 p0 fm1000 ec1",
                     cur_done, cur_pass, cur_fm, cur_ec);
        else passed++;
    endtask

    initial begin
        rst      = 1'b1;
        sel      = 1'b0;
        glitch0  = 1'b0;
        resp0    = 4'b0111;
        resp1    = 4'b1000;
        t0.start = 1'b0;
        t1.start = 1'b0;
        test_reset();
        test_basic();
        test_reset_mid_sweep();
        test_start_held();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/truth_table_checker.md
TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 2: clock cycles each input vector is held before its response is sampled (legal range 1..15).
REQ-002 The block SHALL have parameter EXPECTED, default 4'b0111: expected 2-input truth table, bit i = expected dut_y for vector i = {b,a} (default = NAND).
REQ-003 The block SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  one-cycle request to run a full sweep.
REQ-006 The block SHALL have port dut_y  input  1  response of the gate under test.
REQ-007 The block SHALL have port a  output  1  stimulus bit 0 (vector index bit 0), registered.
REQ-008 The block SHALL have port b  output  1  stimulus bit 1 (vector index bit 1), registered.
REQ-009 The block SHALL have port busy  output  1  high while a sweep is in progress.
REQ-010 The block SHALL have port done  output  1  high from sweep completion until next start or reset.
REQ-011 The block SHALL have port pass  output  1  high when done=1 and no mismatch was recorded; 0 whenever done=0.
REQ-012 The block SHALL have port fail_mask  output  4  bit i set if vector i mismatched in the last sweep.
REQ-013 The block SHALL have port err_count  output  3  number of mismatching vectors in the last sweep (0..4).

Function
REQ-014 The block SHALL implement states IDLE, DRIVE, DONE; vector index vec (2 bits); hold counter hcnt (4 bits).
REQ-015 In IDLE or DONE, start=1 at edge k SHALL, after edge k: state=DRIVE, vec=0, hcnt=0, a=0, b=0, busy=1, done=0, fail_mask=0, err_count=0.
REQ-016 In DRIVE, a and b SHALL equal vec[0] and vec[1] on every cycle; vector order 00, a=1/b=0, a=0/b=1, 11.
REQ-017 In DRIVE, hcnt SHALL increment each edge while hcnt < HOLD_CYCLES-1.
REQ-018 At the edge where hcnt == HOLD_CYCLES-1, dut_y SHALL be sampled and compared with EXPECTED[vec]; on mismatch fail_mask[vec] set and err_count incremented at that same edge.
REQ-019 At that same edge, if vec<3: vec increments and hcnt clears to 0; if vec==3: state=DONE, busy=0, done=1.
REQ-020 A sweep SHALL occupy exactly 4*HOLD_CYCLES cycles with busy=1 (8 cycles at default).
REQ-021 dut_y not equal to 0 or 1 (X/Z in simulation) at the sample edge SHALL count as a mismatch.
REQ-022 start while in DRIVE SHALL be ignored; the sweep continues unaffected.
REQ-023 In DONE, a, b, fail_mask, err_count SHALL hold their final values; pass = (err_count==0).
REQ-024 dut_y SHALL be ignored outside the sample edge of REQ-018.
REQ-025 HOLD_CYCLES=1 SHALL sample on every DRIVE edge (one cycle per vector).

Reset
REQ-026 rst=1 at an edge SHALL force state=IDLE, vec=0, hcnt=0, a=0, b=0, busy=0, done=0, pass=0, fail_mask=0, err_count=0, overriding start.
REQ-027 rst asserted mid-sweep SHALL abort the sweep with no partial results retained; a later start begins a fresh sweep from vector 0.
REQ-028 Outputs SHALL be undefined only before the first edge with rst=1.

Verification
REQ-029 Default params, dut_y = ~(a&b), one-cycle start -> busy high 8 cycles, a/b sequence 00,00,10,10,01,01,11,11, then done=1, pass=1, fail_mask=0000, err_count=0.
REQ-030 Default params, dut_y tied 1 -> done after 8 busy cycles, pass=0, fail_mask=1000, err_count=1.
REQ-031 Default params, dut_y = a&b (AND) -> fail_mask=1111, err_count=4, pass=0.
REQ-032 rst pulsed during vector 2 of a sweep -> next cycle all outputs 0, state IDLE; new start runs full 8-cycle sweep with correct results.
REQ-033 start held high 20 cycles -> exactly one sweep during busy, start in DONE immediately restarts (done drops, counters cleared).
REQ-034 HOLD_CYCLES=1, EXPECTED=4'b1000, dut_y = a&b -> busy 4 cycles, pass=1, err_count=0.
